div_unit: RTL and testbench

Multi-cycle RV32M divider serving the execute stage: accepts one DIV/DIVU/REM/REMU request, computes it with a radix-2 restoring algorithm, and returns the result with a write-back pulse. The execute stage holds the pipeline on `div_busy_o` and forwards `div_rd_addr_o`/`div_result_o` to the register file on `div_done_o`. A jump or flush from the control unit cancels an in-flight operation.

---
 rtl/div_unit_pkg.sv | 43 ++++
 rtl/div_unit_if.sv | 35 +++
 rtl/div_unit.sv | 156 +++++++++++++++
 tb/tb_div_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants, FSM encoding and funct3 helpers for the RV32M divider.
package div_unit_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned CNT_W      = 6;

  // funct3 encodings of the M-extension divide group
  localparam logic [FUNCT3_W-1:0] INST_DIV  = 3'b100;
  localparam logic [FUNCT3_W-1:0] INST_DIVU = 3'b101;
  localparam logic [FUNCT3_W-1:0] INST_REM  = 3'b110;
  localparam logic [FUNCT3_W-1:0] INST_REMU = 3'b111;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_CALC  = 2'd2,
    S_END   = 2'd3
  } state_t;

  // Signed variants: DIV and REM
  function automatic logic is_signed_op(input logic [FUNCT3_W-1:0] f3);
    return (f3 == INST_DIV) || (f3 == INST_REM);
  endfunction

  // Remainder variants: REM and REMU
  function automatic logic is_rem_op(input logic [FUNCT3_W-1:0] f3);
    return (f3 == INST_REM) || (f3 == INST_REMU);
  endfunction

  // Unrecognised funct3 codes are executed as DIVU
  function automatic logic [FUNCT3_W-1:0] legal_funct3(input logic [FUNCT3_W-1:0] f3);
    logic [FUNCT3_W-1:0] r;
    r = INST_DIVU;
    if ((f3 == INST_DIV) || (f3 == INST_DIVU) || (f3 == INST_REM) || (f3 == INST_REMU))
      r = f3;
    return r;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider request/result bundle.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) ();

  logic                  div_start_i;
  logic [FUNCT3_W-1:0]   div_funct3_i;
  logic [WIDTH-1:0]      div_dividend_i;
  logic [WIDTH-1:0]      div_divisor_i;
  logic [REG_ADDR_W-1:0] div_rd_addr_i;
  logic                  div_flush_i;

  logic                  div_busy_o;
  logic                  div_done_o;
  logic                  div_rd_wr_en_o;
  logic [REG_ADDR_W-1:0] div_rd_addr_o;
  logic [WIDTH-1:0]      div_result_o;

  // Execute stage / control side
  modport master (
    output div_start_i, div_funct3_i, div_dividend_i, div_divisor_i,
           div_rd_addr_i, div_flush_i,
    input  div_busy_o, div_done_o, div_rd_wr_en_o, div_rd_addr_o, div_result_o
  );

  // Divider side
  modport slave (
    input  div_start_i, div_funct3_i, div_dividend_i, div_divisor_i,
           div_rd_addr_i, div_flush_i,
    output div_busy_o, div_done_o, div_rd_wr_en_o, div_rd_addr_o, div_result_o
  );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(WIDTH - 1);

  // Two's-complement negate, shared by operand and result correction
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  state_t                state, state_next;

  logic [FUNCT3_W-1:0]   op_q;
  logic [WIDTH-1:0]      dvd_q;      // dividend, shifted into the quotient
  logic [WIDTH-1:0]      dvs_q;      // divisor magnitude
  logic [WIDTH-1:0]      rem_q;      // partial remainder
  logic [CNT_W-1:0]      cnt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  neg_q_q;
  logic                  neg_r_q;

  logic                  accept;
  logic                  op_signed;
  logic                  dvs_zero;
  logic                  overflow;
  logic [WIDTH:0]        shifted;
  logic [WIDTH:0]        diff;
  logic [WIDTH-1:0]      quo_fix;
  logic [WIDTH-1:0]      rem_fix;
  logic                  busy;
  logic                  done;

  assign accept    = bus.div_start_i && !bus.div_flush_i;
  assign op_signed = is_signed_op(op_q);
  assign dvs_zero  = (dvs_q == ZERO_WORD);
  assign overflow  = op_signed && (dvd_q == MIN_NEG) && (dvs_q == ALL_ONES);

  // One restoring step: shift in the next dividend bit and trial-subtract
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  // Sign correction of the final quotient and remainder
  assign quo_fix = neg_q_q ? negate(dvd_q) : dvd_q;
  assign rem_fix = neg_r_q ? negate(rem_q) : rem_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and state-decoded status
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_next = S_START;
      end
      S_START: begin
        busy = 1'b1;
        if (bus.div_flush_i)            state_next = S_IDLE;
        else if (dvs_zero || overflow)  state_next = S_END;
        else                            state_next = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (bus.div_flush_i)       state_next = S_IDLE;
        else if (cnt_q == LAST_IT) state_next = S_END;
      end
      S_END: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture, special-case setup and iteration datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= INST_DIVU;
      dvd_q   <= ZERO_WORD;
      dvs_q   <= ZERO_WORD;
      rem_q   <= ZERO_WORD;
      cnt_q   <= '0;
      rd_q    <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= legal_funct3(bus.div_funct3_i);
            dvd_q <= bus.div_dividend_i;
            dvs_q <= bus.div_divisor_i;
            rd_q  <= bus.div_rd_addr_i;
          end
        end
        S_START: begin
          cnt_q <= '0;
          if (dvs_zero) begin
            // x/0: quotient all ones, remainder is the dividend
            rem_q   <= dvd_q;
            dvd_q   <= ALL_ONES;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
          end else if (overflow) begin
            // MIN/-1: quotient MIN, remainder zero
            rem_q   <= ZERO_WORD;
            dvd_q   <= MIN_NEG;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
          end else begin
            rem_q <= ZERO_WORD;
            if (op_signed) begin
              dvd_q   <= dvd_q[WIDTH-1] ? negate(dvd_q) : dvd_q;
              dvs_q   <= dvs_q[WIDTH-1] ? negate(dvs_q) : dvs_q;
              neg_q_q <= dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
              neg_r_q <= dvd_q[WIDTH-1];
            end else begin
              neg_q_q <= 1'b0;
              neg_r_q <= 1'b0;
            end
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          dvd_q <= {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
          if (!diff[WIDTH]) rem_q <= diff[WIDTH-1:0];
          else              rem_q <= shifted[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.div_busy_o     = busy;
  assign bus.div_done_o     = done;
  assign bus.div_rd_wr_en_o = done;
  assign bus.div_rd_addr_o  = rd_q;
  assign bus.div_result_o   = !done         ? ZERO_WORD :
                              is_rem_op(op_q) ? rem_fix : quo_fix;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, special cases, flush, reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.div_start_i    = 1'b0;
    bus.div_flush_i    = 1'b0;
    bus.div_funct3_i   = 3'b000;
    bus.div_dividend_i = 32'h0;
    bus.div_divisor_i  = 32'h0;
    bus.div_rd_addr_i  = 5'd0;
  endtask

  // Count done pulses over a number of cycles
  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.div_done_o) seen++;
      next_cycle();
    end
  endtask

  // Issue one request in the current cycle and check latency, result and write-back
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat, input bit scramble);
    int k;
    int lat;
    bus.div_start_i    = 1'b1;
    bus.div_funct3_i   = f3;
    bus.div_dividend_i = a;
    bus.div_divisor_i  = b;
    bus.div_rd_addr_i  = rd;
    next_cycle();
    bus.div_start_i = 1'b0;
    check({tag, "_busy_n1"}, 32'(bus.div_busy_o), 32'd1);
    k   = 1;
    lat = 0;
    while (k <= 60 && lat == 0) begin
      if (bus.div_done_o) begin
        lat = k;
      end else begin
        if (scramble && k == 5) begin
          bus.div_dividend_i = 32'hDEAD_BEEF;
          bus.div_divisor_i  = 32'h0000_0003;
          bus.div_funct3_i   = INST_REM;
          bus.div_rd_addr_i  = 5'd31;
          bus.div_start_i    = 1'b1;
        end
        next_cycle();
        k++;
      end
    end
    bus.div_start_i = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, bus.div_result_o, exp);
    check({tag, "_rd"}, 32'(bus.div_rd_addr_o), 32'(rd));
    check({tag, "_wr_en"}, 32'(bus.div_rd_wr_en_o), 32'd1);
    check({tag, "_busy_done"}, 32'(bus.div_busy_o), 32'd0);
    next_cycle();
    check({tag, "_done_pulse"}, 32'(bus.div_done_o), 32'd0);
    check({tag, "_wr_en_pulse"}, 32'(bus.div_rd_wr_en_o), 32'd0);
    check({tag, "_result_idle"}, bus.div_result_o, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_busy",   32'(bus.div_busy_o),     32'd0);
    check("rst_done",   32'(bus.div_done_o),     32'd0);
    check("rst_wr_en",  32'(bus.div_rd_wr_en_o), 32'd0);
    check("rst_rd",     32'(bus.div_rd_addr_o),  32'd0);
    check("rst_result", bus.div_result_o,        32'h0);

    run_op("divu_100_7",     INST_DIVU, 32'd100,       32'd7,         5'd5,  32'd14,        34, 1'b0);
    run_op("rem_m7_2",       INST_REM,  32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 34, 1'b0);
    run_op("div_m7_2",       INST_DIV,  32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 34, 1'b0);
    run_op("remu_fff9_2",    INST_REMU, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'd1,         34, 1'b0);
    run_op("div_7_m2",       INST_DIV,  32'd7,         32'hFFFF_FFFE, 5'd9,  32'hFFFF_FFFD, 34, 1'b0);
    run_op("rem_7_m2",       INST_REM,  32'd7,         32'hFFFF_FFFE, 5'd10, 32'd1,         34, 1'b0);
    run_op("div_ovf",        INST_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000,  2, 1'b0);
    run_op("rem_ovf",        INST_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0,          2, 1'b0);
    run_op("divu_5_0",       INST_DIVU, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF,  2, 1'b0);
    run_op("remu_5_0",       INST_REMU, 32'd5,         32'd0,         5'd14, 32'd5,          2, 1'b0);
    run_op("div_m5_0",       INST_DIV,  32'hFFFF_FFFB, 32'd0,         5'd15, 32'hFFFF_FFFF,  2, 1'b0);
    run_op("rem_m5_0",       INST_REM,  32'hFFFF_FFFB, 32'd0,         5'd16, 32'hFFFF_FFFB,  2, 1'b0);
    run_op("bad_f3_as_divu", 3'b000,    32'hFFFF_FFF9, 32'd2,         5'd17, 32'h7FFF_FFFC, 34, 1'b0);

    // Flush in N+10, idle in N+11, new request in N+12 completes in N+46
    bus.div_start_i    = 1'b1;
    bus.div_funct3_i   = INST_DIVU;
    bus.div_dividend_i = 32'd100;
    bus.div_divisor_i  = 32'd7;
    bus.div_rd_addr_i  = 5'd3;
    next_cycle();
    bus.div_start_i = 1'b0;
    repeat (9) next_cycle();
    bus.div_flush_i = 1'b1;
    next_cycle();
    bus.div_flush_i = 1'b0;
    check("flush_busy", 32'(bus.div_busy_o), 32'd0);
    check("flush_done", 32'(bus.div_done_o), 32'd0);
    next_cycle();
    run_op("after_flush_scrambled", INST_DIVU, 32'd1000, 32'd10, 5'd20, 32'd100, 34, 1'b1);

    // Synchronous reset in N+20 aborts the operation
    bus.div_start_i    = 1'b1;
    bus.div_funct3_i   = INST_DIV;
    bus.div_dividend_i = 32'd12345;
    bus.div_divisor_i  = 32'd11;
    bus.div_rd_addr_i  = 5'd21;
    next_cycle();
    bus.div_start_i = 1'b0;
    repeat (19) next_cycle();
    rst = 1'b1;
    next_cycle();
    check("midrst_busy",   32'(bus.div_busy_o),     32'd0);
    check("midrst_done",   32'(bus.div_done_o),     32'd0);
    check("midrst_wr_en",  32'(bus.div_rd_wr_en_o), 32'd0);
    check("midrst_rd",     32'(bus.div_rd_addr_o),  32'd0);
    check("midrst_result", bus.div_result_o,        32'h0);
    rst = 1'b0;
    count_done(40, seen);
    check("midrst_no_done", 32'(seen), 32'd0);

    // Start and flush together in IDLE: nothing accepted
    bus.div_start_i    = 1'b1;
    bus.div_flush_i    = 1'b1;
    bus.div_funct3_i   = INST_DIVU;
    bus.div_dividend_i = 32'd9;
    bus.div_divisor_i  = 32'd0;
    bus.div_rd_addr_i  = 5'd22;
    next_cycle();
    idle_inputs();
    check("start_flush_busy", 32'(bus.div_busy_o), 32'd0);
    count_done(40, seen);
    check("start_flush_no_done", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
